// File: rtl/armleocpu_defs_pkg.sv
// Shared definitions for the memory-bus arbiter: state encodings and default burst width.
package armleocpu_defs;

  localparam int unsigned ARB_BURST_W = 4;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_RD_CMD  = 2'd1;
  localparam logic [1:0] ARB_RD_DATA = 2'd2;
  localparam logic [1:0] ARB_WR      = 2'd3;

endpackage

// File: rtl/armleocpu_rr_pick2.sv
// Two-requester grant picker: round robin by default, port 1 fixed priority
// when ARMLEOCPU_MEM_ARB_FIXED_PRIO_EN is defined.
module armleocpu_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

`ifdef ARMLEOCPU_MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant = req[1];
`else
  // On a tie the port that was not served last wins.
  always_comb begin
    grant = req[1];
    if (req == 2'b11)
      grant = ~last_grant;
  end
`endif

endmodule

// File: rtl/armleocpu_mem_arbiter.sv
// Two-master burst memory bus arbiter (port 0 icache, port 1 dcache); one whole burst per grant.
// Optional ARMLEOCPU_MEM_ARB_FIXED_PRIO_EN makes port 1 win simultaneous requests.
module armleocpu_mem_arbiter
  import armleocpu_defs::*;
#(
  parameter int unsigned ADDR_W  = 34,
  parameter int unsigned BURST_W = ARB_BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic [ADDR_W-1:0]  c0_address,
  input  logic [BURST_W-1:0] c0_burstcount,
  input  logic               c0_read,
  input  logic               c0_write,
  input  logic [31:0]        c0_writedata,
  input  logic [3:0]         c0_byteenable,
  output logic               c0_waitrequest,
  output logic [31:0]        c0_readdata,
  output logic               c0_readdatavalid,

  input  logic [ADDR_W-1:0]  c1_address,
  input  logic [BURST_W-1:0] c1_burstcount,
  input  logic               c1_read,
  input  logic               c1_write,
  input  logic [31:0]        c1_writedata,
  input  logic [3:0]         c1_byteenable,
  output logic               c1_waitrequest,
  output logic [31:0]        c1_readdata,
  output logic               c1_readdatavalid,

  output logic [ADDR_W-1:0]  m_address,
  output logic [BURST_W-1:0] m_burstcount,
  output logic               m_read,
  output logic               m_write,
  output logic [31:0]        m_writedata,
  output logic [3:0]         m_byteenable,
  input  logic               m_waitrequest,
  input  logic [31:0]        m_readdata,
  input  logic               m_readdatavalid
);

  localparam int unsigned CNT_W = BURST_W + 1;

  logic [1:0]       state, state_n;
  logic             grant, grant_n;
  logic             last_grant, last_grant_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [1:0]         req;
  logic               pick;
  logic               p_read;
  logic [BURST_W-1:0] p_burst;
  logic               g_read, g_write;
  logic               g_wait, g_rdv;

  assign req     = {c1_read | c1_write, c0_read | c0_write};
  assign p_read  = pick ? c1_read : c0_read;
  assign p_burst = pick ? c1_burstcount : c0_burstcount;
  assign g_read  = grant ? c1_read : c0_read;
  assign g_write = grant ? c1_write : c0_write;

  armleocpu_rr_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
    end
  end

  // Next-state: burstcount 0 loads 2**BURST_W via the extra counter MSB.
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          grant_n = pick;
          cnt_n   = {p_burst == '0, p_burst};
          state_n = p_read ? ARB_RD_CMD : ARB_WR;
        end
      end
      ARB_RD_CMD: begin
        if (g_read && !m_waitrequest)
          state_n = ARB_RD_DATA;
      end
      ARB_RD_DATA: begin
        if (m_readdatavalid) begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n      = ARB_IDLE;
            last_grant_n = grant;
          end
        end
      end
      ARB_WR: begin
        if (g_write && !m_waitrequest) begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n      = ARB_IDLE;
            last_grant_n = grant;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Outputs: payload muxed by grant, handshakes gated by state.
  always_comb begin
    m_read           = 1'b0;
    m_write          = 1'b0;
    g_wait           = 1'b1;
    g_rdv            = 1'b0;
    c0_waitrequest   = 1'b1;
    c1_waitrequest   = 1'b1;
    c0_readdatavalid = 1'b0;
    c1_readdatavalid = 1'b0;
    m_address        = grant ? c1_address : c0_address;
    m_burstcount     = grant ? c1_burstcount : c0_burstcount;
    m_writedata      = grant ? c1_writedata : c0_writedata;
    m_byteenable     = grant ? c1_byteenable : c0_byteenable;
    c0_readdata      = m_readdata;
    c1_readdata      = m_readdata;
    case (state)
      ARB_RD_CMD: begin
        m_read = g_read;
        g_wait = m_waitrequest;
      end
      ARB_RD_DATA: g_rdv = m_readdatavalid;
      ARB_WR: begin
        m_write = g_write;
        g_wait  = m_waitrequest;
      end
      default: ;
    endcase
    if (grant) begin
      c1_waitrequest   = g_wait;
      c1_readdatavalid = g_rdv;
    end else begin
      c0_waitrequest   = g_wait;
      c0_readdatavalid = g_rdv;
    end
  end

endmodule

// File: tb/tb_armleocpu_mem_arbiter.sv
// Directed self-checking bench for armleocpu_mem_arbiter; honours ARMLEOCPU_MEM_ARB_FIXED_PRIO_EN.
module tb_armleocpu_mem_arbiter;

  localparam logic [33:0] A0 = 34'h0_0000_1000;
  localparam logic [33:0] A1 = 34'h2_0000_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] c0_address, c1_address, m_address;
  logic [3:0]  c0_burstcount, c1_burstcount, m_burstcount;
  logic        c0_read, c0_write, c1_read, c1_write;
  logic [31:0] c0_writedata, c1_writedata, m_writedata;
  logic [3:0]  c0_byteenable, c1_byteenable, m_byteenable;
  logic        c0_waitrequest, c1_waitrequest;
  logic [31:0] c0_readdata, c1_readdata, m_readdata;
  logic        c0_readdatavalid, c1_readdatavalid;
  logic        m_read, m_write, m_waitrequest, m_readdatavalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  armleocpu_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c0_address(c0_address), .c0_burstcount(c0_burstcount), .c0_read(c0_read),
    .c0_write(c0_write), .c0_writedata(c0_writedata), .c0_byteenable(c0_byteenable),
    .c0_waitrequest(c0_waitrequest), .c0_readdata(c0_readdata), .c0_readdatavalid(c0_readdatavalid),
    .c1_address(c1_address), .c1_burstcount(c1_burstcount), .c1_read(c1_read),
    .c1_write(c1_write), .c1_writedata(c1_writedata), .c1_byteenable(c1_byteenable),
    .c1_waitrequest(c1_waitrequest), .c1_readdata(c1_readdata), .c1_readdatavalid(c1_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );

  task automatic reset_dut;
    rst_n = 1'b0;
    c0_address = '0; c0_burstcount = '0; c0_read = 0; c0_write = 0; c0_writedata = '0; c0_byteenable = '0;
    c1_address = '0; c1_burstcount = '0; c1_read = 0; c1_write = 0; c1_writedata = '0; c1_byteenable = '0;
    m_waitrequest = 1'b1; m_readdata = '0; m_readdatavalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_dut();
    @(negedge clk);
    m_readdatavalid = 1'b1;
    m_readdata = 32'h5A5A_1234;
    #1;
    checks++; if (m_read !== 1'b0) begin errors++; $display("FAIL reset m_read: got %b want 0", m_read); end
    checks++; if (m_write !== 1'b0) begin errors++; $display("FAIL reset m_write: got %b want 0", m_write); end
    checks++; if (c0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset c0_waitrequest: got %b want 1", c0_waitrequest); end
    checks++; if (c1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset c1_waitrequest: got %b want 1", c1_waitrequest); end
    checks++; if (c0_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset c0_readdatavalid: got %b want 0", c0_readdatavalid); end
    checks++; if (c1_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset c1_readdatavalid: got %b want 0", c1_readdatavalid); end
    checks++; if (c1_readdata !== 32'h5A5A_1234) begin errors++; $display("FAIL readdata passthrough: got %h want 5a5a1234", c1_readdata); end
  endtask

  task automatic test_single_read;
    reset_dut();
    @(negedge clk);
    c0_address = A0; c0_burstcount = 4'd4; c0_read = 1'b1;
    #1;
    checks++; if (m_read !== 1'b0) begin errors++; $display("FAIL single arb latency m_read: got %b want 0", m_read); end
    @(negedge clk);
    m_waitrequest = 1'b0;
    #1;
    checks++; if (m_read !== 1'b1) begin errors++; $display("FAIL single cmd m_read: got %b want 1", m_read); end
    checks++; if (m_address !== A0 || m_burstcount !== 4'd4) begin errors++; $display("FAIL single cmd addr/burst: got %h/%0d want %h/4", m_address, m_burstcount, A0); end
    checks++; if (c0_waitrequest !== 1'b0 || c1_waitrequest !== 1'b1) begin errors++; $display("FAIL single cmd waits: got %b%b want 01", c0_waitrequest, c1_waitrequest); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c0_read = 1'b0; m_waitrequest = 1'b1;
      m_readdatavalid = 1'b1; m_readdata = 32'hA0 + 32'(i);
      #1;
      checks++; if (c0_readdatavalid !== 1'b1 || c0_readdata !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL single beat %0d: got v=%b d=%h want v=1 d=%h", i, c0_readdatavalid, c0_readdata, 32'hA0 + 32'(i)); end
      checks++; if (c1_readdatavalid !== 1'b0 || m_read !== 1'b0) begin errors++; $display("FAIL single beat %0d c1v/m_read: got %b/%b want 0/0", i, c1_readdatavalid, m_read); end
    end
    // Spurious fifth beat lands in IDLE; a new request starts the back-to-back burst.
    @(negedge clk);
    m_readdata = 32'hEE; c0_address = A0 + 34'h40; c0_burstcount = 4'd1; c0_read = 1'b1;
    #1;
    checks++; if (c0_readdatavalid !== 1'b0) begin errors++; $display("FAIL single extra beat forwarded: got %b want 0", c0_readdatavalid); end
    checks++; if (m_read !== 1'b0 || c0_waitrequest !== 1'b1) begin errors++; $display("FAIL single idle: got m_read=%b c0_wait=%b want 0/1", m_read, c0_waitrequest); end
    @(negedge clk);
    m_readdatavalid = 1'b0;
    #1;
    checks++; if (m_read !== 1'b1 || m_address !== A0 + 34'h40) begin errors++; $display("FAIL back_to_back: got m_read=%b addr=%h want 1/%h", m_read, m_address, A0 + 34'h40); end
  endtask

  task automatic test_arbitration;
    int   exp_g;
    logic gw, lw, gv, lv;
    reset_dut();
    c0_address = A0; c1_address = A1; c0_burstcount = 4'd2; c1_burstcount = 4'd2;
    for (int r = 0; r < 3; r++) begin
`ifdef ARMLEOCPU_MEM_ARB_FIXED_PRIO_EN
      exp_g = 1;
`else
      exp_g = r % 2;
`endif
      @(negedge clk);
      c0_read = 1'b1; c1_read = 1'b1; m_readdatavalid = 1'b0; m_waitrequest = 1'b1;
      #1;
      checks++; if (m_read !== 1'b0 || c0_waitrequest !== 1'b1 || c1_waitrequest !== 1'b1) begin errors++; $display("FAIL arb r%0d idle: got m_read=%b waits=%b%b want 0/11", r, m_read, c0_waitrequest, c1_waitrequest); end
      @(negedge clk);
      m_waitrequest = 1'b0;
      #1;
      gw = (exp_g != 0) ? c1_waitrequest : c0_waitrequest;
      lw = (exp_g != 0) ? c0_waitrequest : c1_waitrequest;
      checks++; if (m_read !== 1'b1 || m_address !== ((exp_g != 0) ? A1 : A0)) begin errors++; $display("FAIL arb r%0d grant: got m_read=%b addr=%h want 1/port%0d", r, m_read, m_address, exp_g); end
      checks++; if (gw !== 1'b0 || lw !== 1'b1) begin errors++; $display("FAIL arb r%0d cmd waits: got winner=%b loser=%b want 0/1", r, gw, lw); end
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        m_waitrequest = 1'b1;
        if (exp_g != 0) c1_read = 1'b0; else c0_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'hB000 + 32'(r * 16 + b);
        #1;
        gv = (exp_g != 0) ? c1_readdatavalid : c0_readdatavalid;
        lv = (exp_g != 0) ? c0_readdatavalid : c1_readdatavalid;
        lw = (exp_g != 0) ? c0_waitrequest : c1_waitrequest;
        checks++; if (gv !== 1'b1 || lv !== 1'b0 || lw !== 1'b1) begin errors++; $display("FAIL arb r%0d beat %0d: got wv=%b lv=%b lw=%b want 1/0/1", r, b, gv, lv, lw); end
      end
    end
  endtask

  task automatic test_write_burst;
    int k = 0;
    int rd_seen = -1;
    reset_dut();
    @(negedge clk);
    c1_address = A1; c1_burstcount = 4'd0; c1_write = 1'b1;
    c1_writedata = 32'hD000_0000; c1_byteenable = 4'hF;
    #1;
    checks++; if (m_write !== 1'b0) begin errors++; $display("FAIL wr idle m_write: got %b want 0", m_write); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      m_waitrequest = (i % 2 == 1);
      c1_write = (k < 16);
      c1_writedata = 32'hD000_0000 + 32'(k);
      c1_byteenable = 4'(k ^ 15);
      if (i == 3) begin c0_address = A0; c0_burstcount = 4'd1; c0_read = 1'b1; end
      #1;
      if (k < 16) begin
        checks++; if (c0_waitrequest !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL wr cyc %0d port0 not stalled: got wait=%b m_read=%b want 1/0", i, c0_waitrequest, m_read); end
      end
      if (m_write === 1'b1 && m_waitrequest === 1'b0) begin
        checks++; if (m_writedata !== 32'hD000_0000 + 32'(k) || m_byteenable !== 4'(k ^ 15) || m_address !== A1) begin errors++; $display("FAIL wr beat %0d: got d=%h be=%h a=%h want d=%h be=%h", k, m_writedata, m_byteenable, m_address, 32'hD000_0000 + 32'(k), 4'(k ^ 15)); end
        k++;
      end
      if (m_read === 1'b1 && rd_seen < 0) rd_seen = i;
    end
    checks++; if (k != 16) begin errors++; $display("FAIL wr beat count: got %0d want 16", k); end
    checks++; if (rd_seen != 32) begin errors++; $display("FAIL wr port0 read start cycle: got %0d want 32", rd_seen); end
  endtask

  task automatic test_wait_hold;
    reset_dut();
    @(negedge clk);
    c0_address = A0 + 34'h80; c0_burstcount = 4'd3; c0_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_waitrequest = 1'b1;
      #1;
      checks++; if (m_read !== 1'b1 || m_address !== A0 + 34'h80 || m_burstcount !== 4'd3) begin errors++; $display("FAIL hold cyc %0d cmd: got rd=%b a=%h bc=%0d want 1/%h/3", i, m_read, m_address, m_burstcount, A0 + 34'h80); end
      checks++; if (c0_waitrequest !== 1'b1) begin errors++; $display("FAIL hold cyc %0d c0_waitrequest: got %b want 1", i, c0_waitrequest); end
    end
    @(negedge clk);
    m_waitrequest = 1'b0;
    #1;
    checks++; if (c0_waitrequest !== 1'b0) begin errors++; $display("FAIL hold release c0_waitrequest: got %b want 0", c0_waitrequest); end
  endtask

  task automatic test_reset_mid_burst;
    reset_dut();
    @(negedge clk);
    c0_address = A0; c0_burstcount = 4'd8; c0_read = 1'b1;
    @(negedge clk);
    m_waitrequest = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      c0_read = 1'b0; m_waitrequest = 1'b1; m_readdatavalid = 1'b1; m_readdata = 32'(b + 1);
      #1;
      checks++; if (c0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rstmid beat %0d: got %b want 1", b, c0_readdatavalid); end
    end
    @(negedge clk);
    m_readdata = 32'h3;
    #1;
    checks++; if (c0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rstmid pre-reset beat: got %b want 1", c0_readdatavalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (c0_readdatavalid !== 1'b0 || c1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rstmid async rdv: got %b%b want 00", c0_readdatavalid, c1_readdatavalid); end
    checks++; if (c0_waitrequest !== 1'b1 || c1_waitrequest !== 1'b1) begin errors++; $display("FAIL rstmid async waits: got %b%b want 11", c0_waitrequest, c1_waitrequest); end
    checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++; $display("FAIL rstmid async m_rd/m_wr: got %b%b want 00", m_read, m_write); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_readdata = 32'h10 + 32'(i);
      #1;
      checks++; if (c0_readdatavalid !== 1'b0 || c1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rstmid late beat %0d forwarded: got %b%b want 00", i, c0_readdatavalid, c1_readdatavalid); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_write_burst();
    test_wait_hold();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
